// File: rtl/if_pkg.sv
// if_pkg: shared defaults and pointer-width helper for the prefetch front end
package if_pkg;
    localparam int unsigned ADDR_W_D   = 32;
    localparam int unsigned DATA_W_D   = 32;
    localparam int unsigned DEPTH_D    = 4;
    localparam int unsigned PC_INC_D   = 1;
    localparam int unsigned RESET_PC_D = 0;
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/if_pf_ring.sv
// if_pf_ring: prefetch slot storage, pc written at alloc, data written at fill, async read at rd
module if_pf_ring #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              pc_we,
    input  logic [IW-1:0]     pc_idx,
    input  logic [ADDR_W-1:0] pc_wdata,
    input  logic              data_we,
    input  logic [IW-1:0]     data_idx,
    input  logic [DATA_W-1:0] data_wdata,
    input  logic [IW-1:0]     rd_idx,
    output logic [ADDR_W-1:0] rd_pc,
    output logic [DATA_W-1:0] rd_data
);
    logic [ADDR_W-1:0] pcs  [DEPTH];
    logic [DATA_W-1:0] data [DEPTH];

    assign rd_pc   = pcs[rd_idx];
    assign rd_data = data[rd_idx];

    // slot writes: pc lands when the request is granted, data when its response returns
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                pcs[i]  <= '0;
                data[i] <= '0;
            end
        end else begin
            if (pc_we) pcs[pc_idx] <= pc_wdata;
            if (data_we) data[data_idx] <= data_wdata;
        end
    end
endmodule

// File: rtl/if_prefetch.sv
// if_prefetch: sequential instruction fetch with an in-order prefetch queue and branch flush
module if_prefetch import if_pkg::*; #(
    parameter int          ADDR_W   = ADDR_W_D,
    parameter int          DATA_W   = DATA_W_D,
    parameter int          DEPTH    = DEPTH_D,
    parameter int unsigned PC_INC   = PC_INC_D,
    parameter int unsigned RESET_PC = RESET_PC_D
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              pc_WPC,
    input  logic              tf_out,
    input  logic [ADDR_W-1:0] alu_result,
    output logic              im_req,
    output logic [ADDR_W-1:0] im_addr,
    input  logic              im_gnt,
    input  logic              im_rvalid,
    input  logic [DATA_W-1:0] im_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc
);
    localparam int PW = ptr_w(DEPTH);
    localparam int IW = PW - 1;
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

    logic [ADDR_W-1:0] pc;
    logic [PW-1:0] alloc, fill, rd, disc, occ, disc_flush;
    logic grant, take, drop, pop;

    assign occ        = alloc - rd;
    assign im_req     = ~RST & pc_WPC & ~tf_out & (({1'b0, occ} + {1'b0, disc}) < DEPTH_C);
    assign im_addr    = pc;
    assign grant      = im_req & im_gnt;
    assign drop       = im_rvalid & (disc != '0);
    assign take       = im_rvalid & (disc == '0);
    assign inst_valid = (fill != rd) & ~tf_out;
    assign pop        = inst_valid & inst_ready;
    // every response still owed after this cycle becomes stale on a redirect
    assign disc_flush = (alloc - fill) - PW'(take) + disc - PW'(drop);

    if_pf_ring #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_ring (
        .CLK        (CLK),
        .RST        (RST),
        .pc_we      (grant),
        .pc_idx     (alloc[IW-1:0]),
        .pc_wdata   (pc),
        .data_we    (take & ~tf_out),
        .data_idx   (fill[IW-1:0]),
        .data_wdata (im_rdata),
        .rd_idx     (rd[IW-1:0]),
        .rd_pc      (inst_pc),
        .rd_data    (inst_data)
    );

    // pc, queue pointers and discard count; redirect overrides grant, fill and pop
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc    <= ADDR_W'(RESET_PC);
            alloc <= '0;
            fill  <= '0;
            rd    <= '0;
            disc  <= '0;
        end else if (tf_out) begin
            pc    <= alu_result;
            alloc <= '0;
            fill  <= '0;
            rd    <= '0;
            disc  <= disc_flush;
        end else begin
            if (grant) begin
                alloc <= alloc + 1'b1;
                pc    <= pc + ADDR_W'(PC_INC);
            end
            if (take) fill <= fill + 1'b1;
            if (drop) disc <= disc - 1'b1;
            if (pop) rd <= rd + 1'b1;
        end
    end
endmodule

// File: doc/if_prefetch.md
# if_prefetch

Parametrised instruction-fetch front end with an in-order prefetch queue. It replaces the single-PC, single-read fetch path: it issues sequential fetch requests to instruction memory over a request/grant, response-valid handshake, buffers up to DEPTH instructions with their PCs, and feeds decode through a valid/ready port. A taken branch (`tf_out`) redirects the PC to `alu_result`, flushes the queue and discards responses still in flight.

## Interface
- `ADDR_W`, default 32: PC and memory address width.
- `DATA_W`, default 32: instruction width.
- `DEPTH`, default 4: queue slots; must be a power of 2 and ≥2. Use ≥3 for full throughput.
- `PC_INC`, default 1: PC increment per fetch (word addressing).
- `RESET_PC`, default 0: PC after reset.
- `CLK` in 1: clock; all state updates on the rising edge.
- `RST` in 1: reset, asynchronous, active-high.
- `pc_WPC` in 1: fetch enable; 0 blocks new requests.
- `tf_out` in 1: branch taken; redirects the PC.
- `alu_result` in ADDR_W: redirect target.
- `im_req` out 1: fetch request.
- `im_addr` out ADDR_W: request address, equal to the current PC.
- `im_gnt` in 1: memory accepts the request this cycle.
- `im_rvalid` in 1: response valid. Responses come back in order, one per grant, no earlier than the cycle after the grant.
- `im_rdata` in DATA_W: response data.
- `inst_valid` out 1: queue head holds a filled instruction.
- `inst_ready` in 1: decode accepts the head.
- `inst_data` out DATA_W: head instruction.
- `inst_pc` out ADDR_W: PC of the head instruction.

## Operation
- State:
  - `pc`.
  - Ring buffer of DEPTH slots, each holding {pc, data}.
  - Pointers `alloc`, `fill` and `rd`, each log2(DEPTH)+1 bits wide (wrap bit).
  - Discard counter `disc`, 0..DEPTH.
- Occupancy is `occ = alloc − rd`, modular, and counts in-flight plus filled slots. Filled count is `fill − rd`.
- Request condition: `im_req = pc_WPC & ~tf_out & (occ + disc < DEPTH)`. It uses registered state only; a same-cycle pop does not free credit.
- Grant (`im_req & im_gnt`): write `pc` into slot `alloc`, increment `alloc`, set `pc ← pc + PC_INC` (wraps modulo 2^ADDR_W).
- Response (`im_rvalid`):
  - If `disc > 0`: decrement `disc` and drop the data.
  - Otherwise: write `im_rdata` into slot `fill` and increment `fill`.
- Output: `inst_valid = (fill ≠ rd) & ~tf_out`. A pop (`inst_valid & inst_ready`) increments `rd`.
- Redirect (`tf_out = 1`) has priority over everything else that cycle:
  - `pc ← alu_result`.
  - `alloc`, `fill` and `rd` all reset to 0.
  - `disc ← (alloc − fill) − (im_rvalid & disc == 0 ? 1 : 0) + disc − (im_rvalid & disc > 0 ? 1 : 0)`. In words: every in-flight response not consumed this cycle becomes stale. Any response arriving in the redirect cycle is dropped.
  - No pop, no grant.
- Simultaneous grant, response and pop in one cycle are all legal and applied together.
- Full: `occ + disc = DEPTH`, so `im_req = 0`. Empty: `inst_valid = 0`.
- `pc_WPC = 0`: no new requests; outstanding responses still fill and the queue still drains.

## Timing
- Reset values (asynchronous, while `RST` is high):
  - `pc = RESET_PC`, all pointers 0, `disc = 0`, slot contents 0.
  - Outputs: `im_req = 0`, `im_addr = RESET_PC`, `inst_valid = 0`, `inst_data = 0`, `inst_pc = 0`.
- Reset asserted mid-operation abandons in-flight requests. Memory must also be reset; no discard is carried across reset.
- Latency: grant in cycle N, response at the earliest in N+1, `inst_valid` at the earliest in N+2.
- Throughput: one instruction per cycle when `DEPTH ≥ 3`, `im_gnt = 1`, responses arrive 1 cycle after grant, and `inst_ready = 1`.
- `im_addr` changes only after a grant, on redirect, or at reset.
- While `im_gnt = 0`, `im_req` and `im_addr` hold unless `tf_out` or `pc_WPC` changes.
- First request after a redirect is issued in the cycle after `tf_out`, to `alu_result`.

## Structure
- Package `if_pkg`: default values for `ADDR_W`, `DATA_W`, `DEPTH`, `PC_INC` and `RESET_PC`, plus the pointer-width helper (clog2(DEPTH)+1).
- Sub-module `if_pf_ring`: slot storage with separate pc-write (alloc) and data-write (fill) ports and one asynchronous read port (rd).
- Pointer, credit and discard logic stay in `if_prefetch`.

## Test plan
All scenarios use `DEPTH = 4`, `PC_INC = 1`, `RESET_PC = 0`.
- Reset: `RST` pulsed high mid-stream → all outputs at their reset values immediately, without waiting for `CLK`; after release, `im_addr = 0` and `im_req = 1` when `pc_WPC = 1`.
- Stream: `im_gnt = 1`, response 1 cycle after grant with data = address + 0x100, `inst_ready = 1` → `im_addr` steps 0, 1, 2, …; `inst_pc`/`inst_data` steps 0/0x100, 1/0x101, … with one instruction per cycle; first `inst_valid` 2 cycles after the first grant.
- Backpressure: `inst_ready = 0` → exactly 4 grants (addresses 0–3), then `im_req = 0`. Raising `inst_ready` pops pc 0 first; the next request, to address 4, is issued the cycle after the pop.
- Redirect: 2 requests in flight, `tf_out = 1` with `alu_result = 0x40` → the next 2 responses are dropped, the next `im_addr` is 0x40, and the first `inst_pc` after the flush is 0x40.
- Stalls: `pc_WPC = 0` → no new `im_req`, queued entries still drain in order. `im_gnt = 0` for 3 cycles → `im_req` and `im_addr` held stable throughout.
